// File: rtl/morse_receptor_if.sv
// Character bus between a Morse key receiver and its consumer.
// The DUT uses the slave modport; the key source and the character sink use master.
interface morse_receptor_if;
    logic       tecla;
    logic [6:0] caracter;
    logic       valido;
    logic       error;

    modport master (output tecla, input caracter, input valido, input error);
    modport slave  (input tecla, output caracter, output valido, output error);
endinterface

// File: rtl/morse_receptor.sv
// Morse key receiver: times key presses and gaps, then emits ASCII letters and word spaces.
// Define MORSE_RX_DIGITS_EN to accept 5-element digit patterns (MAXLEN 5 instead of 4).
module morse_receptor #(
    parameter int unsigned UNIT_CYCLES = 5000000
) (
    input  logic            clk,
    input  logic            rst,
    morse_receptor_if.slave bus
);
    localparam int unsigned CW = $clog2(8 * UNIT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_SAT  = CW'(8 * UNIT_CYCLES);
    localparam logic [CW-1:0] DASH_MIN = CW'(2 * UNIT_CYCLES);
    localparam logic [CW-1:0] GAP_CHAR = CW'(3 * UNIT_CYCLES);
    localparam logic [CW-1:0] GAP_WORD = CW'(7 * UNIT_CYCLES);
`ifdef MORSE_RX_DIGITS_EN
    localparam logic [2:0] MAXLEN = 3'd5;
`else
    localparam logic [2:0] MAXLEN = 3'd4;
`endif

    localparam logic [2:0] IDLE           = 3'd0;
    localparam logic [2:0] MARCA          = 3'd1;
    localparam logic [2:0] PAUSA          = 3'd2;
    localparam logic [2:0] ESPERA_PALABRA = 3'd3;
    localparam logic [2:0] DESCARTE       = 3'd4;

    logic [1:0]    sync_q;
    logic          k, k_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    estado_q, estado_d;
    logic [2:0]    len_q, len_d;
    logic [4:0]    pat_q, pat_d;
    logic [6:0]    caracter_q, caracter_d;
    logic          valido_q, valido_d;
    logic          error_q, error_d;
    logic          gap_char, gap_word;
    logic [7:0]    hit;

    // Returns {valid, ascii}; pat holds the elements right-aligned, first element highest.
    function automatic logic [7:0] lookup(input logic [2:0] n, input logic [4:0] p);
        logic [7:0] r;
        r = 8'h00;
        case ({n, p})
            8'b010_00001: r = {1'b1, 7'h41};
            8'b100_01000: r = {1'b1, 7'h42};
            8'b100_01010: r = {1'b1, 7'h43};
            8'b011_00100: r = {1'b1, 7'h44};
            8'b001_00000: r = {1'b1, 7'h45};
            8'b100_00010: r = {1'b1, 7'h46};
            8'b011_00110: r = {1'b1, 7'h47};
            8'b100_00000: r = {1'b1, 7'h48};
            8'b010_00000: r = {1'b1, 7'h49};
            8'b100_00111: r = {1'b1, 7'h4A};
            8'b011_00101: r = {1'b1, 7'h4B};
            8'b100_00100: r = {1'b1, 7'h4C};
            8'b010_00011: r = {1'b1, 7'h4D};
            8'b010_00010: r = {1'b1, 7'h4E};
            8'b011_00111: r = {1'b1, 7'h4F};
            8'b100_00110: r = {1'b1, 7'h50};
            8'b100_01101: r = {1'b1, 7'h51};
            8'b011_00010: r = {1'b1, 7'h52};
            8'b011_00000: r = {1'b1, 7'h53};
            8'b001_00001: r = {1'b1, 7'h54};
            8'b011_00001: r = {1'b1, 7'h55};
            8'b100_00001: r = {1'b1, 7'h56};
            8'b011_00011: r = {1'b1, 7'h57};
            8'b100_01001: r = {1'b1, 7'h58};
            8'b100_01011: r = {1'b1, 7'h59};
            8'b100_01100: r = {1'b1, 7'h5A};
`ifdef MORSE_RX_DIGITS_EN
            8'b101_11111: r = {1'b1, 7'h30};
            8'b101_01111: r = {1'b1, 7'h31};
            8'b101_00111: r = {1'b1, 7'h32};
            8'b101_00011: r = {1'b1, 7'h33};
            8'b101_00001: r = {1'b1, 7'h34};
            8'b101_00000: r = {1'b1, 7'h35};
            8'b101_10000: r = {1'b1, 7'h36};
            8'b101_11000: r = {1'b1, 7'h37};
            8'b101_11100: r = {1'b1, 7'h38};
            8'b101_11110: r = {1'b1, 7'h39};
`endif
            default:      r = 8'h00;
        endcase
        return r;
    endfunction

    assign k = sync_q[1];

    // cnt_q is the length of the run of level k_q; an edge restarts it at one cycle.
    always_comb begin
        if (k != k_q) begin
            cnt_d = CW'(1);
        end else if (cnt_q == CNT_SAT) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign gap_char = !k_q && (cnt_q >= GAP_CHAR);
    assign gap_word = !k_q && (cnt_q >= GAP_WORD);
    assign hit      = lookup(len_q, pat_q);

    always_comb begin
        estado_d   = estado_q;
        len_d      = len_q;
        pat_d      = pat_q;
        caracter_d = caracter_q;
        valido_d   = 1'b0;
        error_d    = 1'b0;
        case (estado_q)
            IDLE: begin
                if (k) estado_d = MARCA;
            end
            MARCA: begin
                if (!k) begin
                    if (len_q == MAXLEN) begin
                        error_d  = 1'b1;
                        len_d    = 3'd0;
                        pat_d    = 5'd0;
                        estado_d = DESCARTE;
                    end else begin
                        pat_d    = {pat_q[3:0], (cnt_q >= DASH_MIN)};
                        len_d    = len_q + 3'd1;
                        estado_d = PAUSA;
                    end
                end
            end
            PAUSA: begin
                // Threshold wins over a press arriving in the same cycle.
                if (gap_char) begin
                    if (hit[7]) begin
                        caracter_d = hit[6:0];
                        valido_d   = 1'b1;
                        estado_d   = ESPERA_PALABRA;
                    end else begin
                        error_d  = 1'b1;
                        estado_d = IDLE;
                    end
                    len_d = 3'd0;
                    pat_d = 5'd0;
                end else if (k) begin
                    estado_d = MARCA;
                end
            end
            ESPERA_PALABRA: begin
                if (gap_word) begin
                    caracter_d = 7'h20;
                    valido_d   = 1'b1;
                    estado_d   = IDLE;
                end else if (k) begin
                    estado_d = MARCA;
                end
            end
            DESCARTE: begin
                if (gap_char) estado_d = IDLE;
            end
            default: estado_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= 2'b00;
            k_q        <= 1'b0;
            cnt_q      <= '0;
            estado_q   <= IDLE;
            len_q      <= 3'd0;
            pat_q      <= 5'd0;
            caracter_q <= 7'h00;
            valido_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], bus.tecla};
            k_q        <= k;
            cnt_q      <= cnt_d;
            estado_q   <= estado_d;
            len_q      <= len_d;
            pat_q      <= pat_d;
            caracter_q <= caracter_d;
            valido_q   <= valido_d;
            error_q    <= error_d;
        end
    end

    assign bus.caracter = caracter_q;
    assign bus.valido   = valido_q;
    assign bus.error    = error_q;
endmodule
